// File: rtl/clock_pkg.sv
// Shared types and constants for the clock setting sequencer.
package clock_pkg;

    localparam int unsigned TW     = 7;
    localparam int unsigned NS_DEF = 60;
    localparam int unsigned NH_DEF = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADV_H,
        ADV_M,
        SETTLE,
        CHECK
    } state_t;

endpackage

// File: rtl/mod_delta.sv
// Combinational forward distance (tgt - cur) mod N for in-range operands.
module mod_delta
    import clock_pkg::*;
#(
    parameter int unsigned N = NS_DEF
) (
    input  logic [TW-1:0] tgt,
    input  logic [TW-1:0] cur,
    output logic [TW-1:0] delta
);

    logic [7:0] raw;

    always_comb begin
        raw   = {1'b0, tgt} + 8'(N) - {1'b0, cur};
        delta = (raw >= 8'(N)) ? TW'(raw - 8'(N)) : TW'(raw);
    end

endmodule

// File: rtl/clock_setter.sv
// Drives the clock core's set/advance buttons until the selected time or
// alarm reads back as the requested hh:mm, with one retry on mismatch.
module clock_setter
    import clock_pkg::*;
#(
    parameter int unsigned NS = NS_DEF,
    parameter int unsigned NH = NH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          alarm_mode,
    input  logic [TW-1:0] tgt_hrs,
    input  logic [TW-1:0] tgt_min,
    input  logic [TW-1:0] cur_hrs,
    input  logic [TW-1:0] cur_min,
    output logic          timeset,
    output logic          alarmset,
    output logic          hrsadv,
    output logic          minadv,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state, state_nx;
    logic          mode_q;
    logic [TW-1:0] hrs_q, min_q;
    logic [TW-1:0] h_cnt, m_cnt;
    logic [TW-1:0] h_delta, m_delta;
    logic          attempt;
    logic          in_range;
    logic          match;

    assign in_range = (tgt_hrs < TW'(NH)) && (tgt_min < TW'(NS));
    assign match    = (cur_hrs == hrs_q) && (cur_min == min_q);

    mod_delta #(.N(NH)) u_hrs_delta (
        .tgt   (hrs_q),
        .cur   (cur_hrs),
        .delta (h_delta)
    );

    mod_delta #(.N(NS)) u_min_delta (
        .tgt   (min_q),
        .cur   (cur_min),
        .delta (m_delta)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            hrs_q   <= '0;
            min_q   <= '0;
            h_cnt   <= '0;
            m_cnt   <= '0;
            attempt <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && in_range) begin
                        mode_q  <= alarm_mode;
                        hrs_q   <= tgt_hrs;
                        min_q   <= tgt_min;
                        attempt <= 1'b0;
                        err     <= 1'b0;
                    end else if (start) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                LOAD: begin
                    h_cnt <= h_delta;
                    m_cnt <= m_delta;
                end
                ADV_H: h_cnt <= h_cnt - 1'b1;
                ADV_M: m_cnt <= m_cnt - 1'b1;
                CHECK: begin
                    if (match) begin
                        done <= 1'b1;
                    end else if (attempt) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end else begin
                        attempt <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Step counters exit on the value 1 so each advance state lasts exactly count cycles.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start && in_range) state_nx = LOAD;
            LOAD: begin
                if (h_delta != '0)      state_nx = ADV_H;
                else if (m_delta != '0) state_nx = ADV_M;
                else                    state_nx = SETTLE;
            end
            ADV_H:  if (h_cnt == TW'(1)) state_nx = (m_cnt != '0) ? ADV_M : SETTLE;
            ADV_M:  if (m_cnt == TW'(1)) state_nx = SETTLE;
            SETTLE: state_nx = CHECK;
            CHECK:  state_nx = (match || attempt) ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        timeset  = busy && !mode_q;
        alarmset = busy && mode_q;
        hrsadv   = (state == ADV_H);
        minadv   = (state == ADV_M);
    end

endmodule
